// File: rtl/demux1_4_stream.sv
// ---------------------------------------------------------------------------
// demux1_4_stream
//   1-to-4 stream router. Each word accepted on the input side is written
//   into the small FIFO of the channel named by in_sel. A stalled consumer
//   therefore blocks only the words addressed to its own channel.
//
//   Optional feature macro: DEMUX_STATS_EN
//     defined   -> four saturating per-channel pop counters, read via
//                  stat_sel / stat_count, cleared by stat_clr.
//     undefined -> no counter flops; stat_count is tied to zero.
//
// Ports
//   clk        : rising-edge clock
//   rst        : asynchronous reset, active-high
//   in_valid   : producer has a word
//   in_ready   : FIFO of channel in_sel is not full
//   in_sel     : destination channel 0..3
//   in_data    : input word
//   out_valid  : bit k set while channel k holds a word
//   out_ready  : bit k set while consumer k accepts
//   out_data   : channel k head word at [k*WIDTH +: WIDTH]
//   stat_sel   : channel whose pop counter drives stat_count
//   stat_clr   : synchronous clear of all pop counters
//   stat_count : pop count of channel stat_sel
// ---------------------------------------------------------------------------
module demux1_4_stream #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic [3:0]         out_valid,
  input  logic [3:0]         out_ready,
  output logic [4*WIDTH-1:0] out_data,
  input  logic [1:0]         stat_sel,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   stat_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   OCC_FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   OCC_ONE_C  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE_C  = AW'(1);

  logic [WIDTH-1:0] r_mem  [4][DEPTH];
  logic [AW-1:0]    r_wptr [4];
  logic [AW-1:0]    r_rptr [4];
  logic [AW:0]      r_occ  [4];

  logic [3:0] w_full_s;
  logic [3:0] w_push_s;
  logic [3:0] w_pop_s;

  // Per-channel full/empty decode and handshake qualification.
  always_comb begin
    w_full_s  = 4'b0000;
    out_valid = 4'b0000;
    w_pop_s   = 4'b0000;
    w_push_s  = 4'b0000;
    out_data  = '0;
    for (int k = 0; k < 4; k++) begin
      w_full_s[k]  = (r_occ[k] == OCC_FULL_C);
      out_valid[k] = (r_occ[k] != '0);
      w_pop_s[k]   = out_valid[k] & out_ready[k];
      out_data[k*WIDTH +: WIDTH] = r_mem[k][r_rptr[k]];
    end
    // in_ready looks only at the selected channel's fullness.
    in_ready = ~w_full_s[in_sel];
    if (in_valid && in_ready) begin
      w_push_s[in_sel] = 1'b1;
    end else begin
      w_push_s = 4'b0000;
    end
  end

  // FIFO storage, pointers and occupancy for all four channels.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_occ[k]  <= '0;
        for (int e = 0; e < DEPTH; e++) begin
          r_mem[k][e] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_push_s[k]) begin
          r_mem[k][r_wptr[k]] <= in_data;
          r_wptr[k]           <= r_wptr[k] + PTR_ONE_C;
        end
        if (w_pop_s[k]) begin
          r_rptr[k] <= r_rptr[k] + PTR_ONE_C;
        end
        // Simultaneous push and pop leaves occupancy unchanged.
        case ({w_push_s[k], w_pop_s[k]})
          2'b10:   r_occ[k] <= r_occ[k] + OCC_ONE_C;
          2'b01:   r_occ[k] <= r_occ[k] - OCC_ONE_C;
          default: r_occ[k] <= r_occ[k];
        endcase
      end
    end
  end

`ifdef DEMUX_STATS_EN
  logic [CNT_W-1:0] r_stat [4];

  // Saturating pop counters; a clear overrides a same-cycle increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_stat[k] <= '0;
      end
    end else if (stat_clr) begin
      for (int k = 0; k < 4; k++) begin
        r_stat[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_pop_s[k] && (r_stat[k] != {CNT_W{1'b1}})) begin
          r_stat[k] <= r_stat[k] + CNT_W'(1);
        end
      end
    end
  end

  assign stat_count = r_stat[stat_sel];
`else
  logic w_unused_stat_s;

  assign stat_count      = '0;
  assign w_unused_stat_s = ^{stat_sel, stat_clr};
`endif

endmodule

// File: tb/tb_demux1_4_stream.sv
// ---------------------------------------------------------------------------
// tb_demux1_4_stream
//   Directed, table-driven bench for demux1_4_stream with DEPTH=2.
//   Vector table walks single pushes, full-channel stalls, pops, back-to-back
//   streaming and push/pop on a full channel. Hand sequences cover reset
//   between clock edges and the statistics counters (both builds).
// ---------------------------------------------------------------------------
module tb_demux1_4_stream;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   in_sel;
  logic [31:0]  in_data;
  logic [3:0]   out_valid;
  logic [3:0]   out_ready;
  logic [127:0] out_data;
  logic [1:0]   stat_sel;
  logic         stat_clr;
  logic [15:0]  stat_count;

  int checks;
  int failures;

  demux1_4_stream #(.WIDTH(32), .DEPTH(2), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stat_sel   (stat_sel),
    .stat_clr   (stat_clr),
    .stat_count (stat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [1:0]  sel;
    logic [31:0] data;
    logic [3:0]  ordy;
    logic        exp_rdy;   // in_ready before the edge
    logic [3:0]  exp_ov;    // out_valid after the edge
    logic        chk_en;
    logic [1:0]  chk_ch;
    logic [31:0] exp_d;     // head of chk_ch after the edge
  } vec_t;

  vec_t vecs [19];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ch_data(input logic [1:0] ch);
    logic [127:0] d;
    d = out_data;
    return d[ch*32 +: 32];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = 2'd0;
    in_data   = 32'h0;
    out_ready = 4'b0000;
    stat_sel  = 2'd0;
    stat_clr  = 1'b0;

    //              vld   sel   data           ordy     rdy   ov       en    ch    exp_d
    vecs[0]  = '{1'b1, 2'd2, 32'hDEADBEEF, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 2'd1, 32'h00000011, 4'b0000, 1'b1, 4'b0110, 1'b1, 2'd1, 32'h00000011};
    vecs[2]  = '{1'b1, 2'd1, 32'h00000022, 4'b0000, 1'b1, 4'b0110, 1'b1, 2'd1, 32'h00000011};
    vecs[3]  = '{1'b0, 2'd1, 32'h00000000, 4'b0000, 1'b0, 4'b0110, 1'b1, 2'd1, 32'h00000011};
    vecs[4]  = '{1'b0, 2'd3, 32'h00000000, 4'b0000, 1'b1, 4'b0110, 1'b1, 2'd2, 32'hDEADBEEF};
    vecs[5]  = '{1'b1, 2'd3, 32'h00000033, 4'b0000, 1'b1, 4'b1110, 1'b1, 2'd3, 32'h00000033};
    vecs[6]  = '{1'b0, 2'd1, 32'h00000000, 4'b0010, 1'b0, 4'b1110, 1'b1, 2'd1, 32'h00000022};
    vecs[7]  = '{1'b0, 2'd1, 32'h00000000, 4'b0010, 1'b1, 4'b1100, 1'b1, 2'd3, 32'h00000033};
    vecs[8]  = '{1'b0, 2'd0, 32'h00000000, 4'b1100, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000};
    vecs[9]  = '{1'b1, 2'd0, 32'h000000A0, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h000000A0};
    vecs[10] = '{1'b1, 2'd0, 32'h000000A1, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h000000A1};
    vecs[11] = '{1'b1, 2'd0, 32'h000000A2, 4'b0001, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h000000A2};
    vecs[12] = '{1'b0, 2'd0, 32'h00000000, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000};
    vecs[13] = '{1'b1, 2'd0, 32'h000000B0, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h000000B0};
    vecs[14] = '{1'b1, 2'd0, 32'h000000B1, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h000000B0};
    vecs[15] = '{1'b1, 2'd0, 32'h000000B2, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h000000B1};
    vecs[16] = '{1'b1, 2'd0, 32'h000000B2, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h000000B1};
    vecs[17] = '{1'b0, 2'd0, 32'h00000000, 4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, 32'h000000B2};
    vecs[18] = '{1'b0, 2'd0, 32'h00000000, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h00000000};

    // Reset state (asserted, no edge needed).
    #2;
    chk("reset_out_valid", {60'h0, out_valid}, 64'h0);
    chk("reset_out_data_lo", {32'h0, out_data[63:0] == 64'h0 ? 32'h0 : 32'h1}, 64'h0);
    chk("reset_out_data_hi", {32'h0, out_data[127:64] == 64'h0 ? 32'h0 : 32'h1}, 64'h0);
    chk("reset_in_ready", {63'h0, in_ready}, 64'h1);
    chk("reset_stat", {48'h0, stat_count}, 64'h0);
    tick();
    rst = 1'b0;
    tick();

    // Table-driven vectors.
    for (int i = 0; i < 19; i++) begin
      in_valid  = vecs[i].vld;
      in_sel    = vecs[i].sel;
      in_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_in_ready", i), {63'h0, in_ready}, {63'h0, vecs[i].exp_rdy});
      tick();
      in_valid = 1'b0;
      chk($sformatf("v%0d_out_valid", i), {60'h0, out_valid}, {60'h0, vecs[i].exp_ov});
      if (vecs[i].chk_en) begin
        chk($sformatf("v%0d_data_ch%0d", i, vecs[i].chk_ch),
            {32'h0, ch_data(vecs[i].chk_ch)}, {32'h0, vecs[i].exp_d});
      end else begin
        chk($sformatf("v%0d_no_data_check_ready", i), {63'h0, in_ready}, 64'h1);
      end
`ifndef DEMUX_STATS_EN
      chk($sformatf("v%0d_stat_zero", i), {48'h0, stat_count}, 64'h0);
`endif
    end
    out_ready = 4'b0000;

    // Reset asserted between edges with three words buffered.
    in_valid = 1'b1;
    in_sel   = 2'd0; in_data = 32'h0000C000; tick();
    in_sel   = 2'd0; in_data = 32'h0000C001; tick();
    in_sel   = 2'd1; in_data = 32'h0000C101; tick();
    in_valid = 1'b0;
    chk("prerst_out_valid", {60'h0, out_valid}, 64'h3);
    chk("prerst_ch1", {32'h0, ch_data(2'd1)}, 64'h0000C101);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {60'h0, out_valid}, 64'h0);
    chk("midrst_ch0", {32'h0, ch_data(2'd0)}, 64'h0);
    #1;
    rst = 1'b0;
    tick();
    chk("postrst_out_valid", {60'h0, out_valid}, 64'h0);
    in_sel = 2'd0;
    #1;
    chk("postrst_in_ready", {63'h0, in_ready}, 64'h1);

    // Statistics: five pops on channel 3, then clear against a same-cycle pop.
    stat_sel = 2'd3;
    stat_clr = 1'b1;
    tick();
    stat_clr  = 1'b0;
    out_ready = 4'b1000;
    in_sel    = 2'd3;
    in_valid  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      in_data = 32'h00005000 + n;
      tick();
    end
    in_valid = 1'b0;
    tick();
    out_ready = 4'b0000;
    chk("stats_ch3_empty", {60'h0, out_valid}, 64'h0);
`ifdef DEMUX_STATS_EN
    chk("stats_count5", {48'h0, stat_count}, 64'd5);
    stat_sel = 2'd0;
    #1;
    chk("stats_ch0_zero", {48'h0, stat_count}, 64'd0);
    stat_sel = 2'd3;
`else
    chk("stats_off_zero", {48'h0, stat_count}, 64'h0);
`endif
    in_valid = 1'b1;
    in_data  = 32'h00005555;
    tick();
    in_valid  = 1'b0;
    out_ready = 4'b1000;
    stat_clr  = 1'b1;
    tick();
    stat_clr  = 1'b0;
    out_ready = 4'b0000;
    chk("stats_clr_pop_empty", {60'h0, out_valid}, 64'h0);
    chk("stats_clr_wins", {48'h0, stat_count}, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
